// File: rtl/nand_share_arbiter.sv
// Round-robin sequencer sharing one registered 2-input NAND among four switch-pair channels.
// Results and status are mirrored onto the EGO1 LED bank.
module nand_share_arbiter #(
    parameter int NCH         = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [2*NCH-1:0] sw_pin,
    output logic [NCH-1:0]   ack,
    output logic [1:0]       gnt_id,
    output logic             busy,
    output logic [15:0]      led_pin
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EVAL,
        DONE
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_gnt;
    logic [1:0] r_last;
    logic       r_op_a;
    logic       r_op_b;
    logic [3:0] r_result;
    logic [3:0] r_valid;
    logic [3:0] r_ack;

    logic [1:0] w_pick;
    logic [1:0] w_idx;
    logic       w_found;

    // Rotating scan starting just past the last served channel.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_pick  = r_last + 2'd1;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_gnt    <= 2'd0;
            r_last   <= 2'd3;
            r_op_a   <= 1'b0;
            r_op_b   <= 1'b0;
            // NOTE: the stored results are deliberately cleared on reset so the LEDs go dark with it.
            r_result <= 4'd0;
            r_valid  <= 4'd0;
            r_ack    <= 4'd0;
        end else begin
            r_ack <= 4'd0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_op_a  <= sw_pin[{r_gnt, 1'b0}];
                    r_op_b  <= sw_pin[{r_gnt, 1'b1}];
                    r_cnt   <= 4'd0;
                    r_state <= EVAL;
                end
                EVAL: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(HOLD_CYCLES - 1)) begin
                        r_result[r_gnt] <= ~(r_op_a & r_op_b);
                        r_valid[r_gnt]  <= 1'b1;
                        r_ack           <= 4'b0001 << r_gnt;
                        r_state         <= DONE;
                    end
                end
                DONE: begin
                    r_last  <= r_gnt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack     = r_ack;
    assign gnt_id  = r_gnt;
    assign busy    = (r_state != IDLE);
    assign led_pin = {5'd0, r_gnt, busy,
                      r_valid[3], r_result[3], r_valid[2], r_result[2],
                      r_valid[1], r_result[1], r_valid[0], r_result[0]};

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Bench for nand_share_arbiter: directed scenarios plus random requesters,
// all compared every cycle against a transaction-timeline reference model.
module tb_nand_share_arbiter;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [7:0]  sw_pin = 8'd0;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] led_pin;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    nand_share_arbiter #(.NCH(4), .HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sw_pin  (sw_pin),
        .ack     (ack),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .led_pin (led_pin)
    );

    always #5 clk = ~clk;

    // Reference model: m_phase counts edges since the arbitration decision, -1 when idle.
    int         m_phase  = -1;
    logic [1:0] m_gnt    = 2'd0;
    logic [1:0] m_last   = 2'd3;
    logic       m_opa    = 1'b0;
    logic       m_opb    = 1'b0;
    logic [3:0] m_result = 4'd0;
    logic [3:0] m_valid  = 4'd0;
    logic [3:0] m_ack    = 4'd0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = -1; m_gnt = 2'd0; m_last = 2'd3;
            m_result = 4'd0; m_valid = 4'd0; m_ack = 4'd0;
        end else if (m_phase < 0) begin
            m_ack = 4'd0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (int'(m_last) + k) % 4;
                if (m_phase < 0 && req[c]) begin
                    m_gnt   = 2'(c);
                    m_phase = 0;
                end
            end
        end else begin
            m_phase++;
            if (m_phase == 1) begin
                m_opa = sw_pin[2*m_gnt];
                m_opb = sw_pin[2*m_gnt+1];
            end
            if (m_phase == H + 1) begin
                m_result[m_gnt] = ~(m_opa & m_opb);
                m_valid[m_gnt]  = 1'b1;
                m_ack           = 4'd0;
                m_ack[m_gnt]    = 1'b1;
            end
            if (m_phase == H + 2) begin
                m_ack   = 4'd0;
                m_last  = m_gnt;
                m_phase = -1;
            end
        end
    end

    function automatic logic [15:0] exp_led();
        logic [15:0] v;
        v = 16'd0;
        for (int i = 0; i < 4; i++) begin
            v[2*i]   = m_result[i];
            v[2*i+1] = m_valid[i];
        end
        v[8]    = (m_phase >= 0);
        v[10:9] = m_gnt;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("ack",  32'(ack),     32'(m_ack));
        check("gnt",  32'(gnt_id),  32'(m_gnt));
        check("busy", 32'(busy),    32'(m_phase >= 0));
        check("led",  32'(led_pin), 32'(exp_led()));
    endtask

    // Waits for ack[ch]; on success the requester drops its request, as a level requester would.
    task automatic wait_ack(input int ch, input int max_cycles, output int lat);
        lat = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            tick();
            if (ack[ch] && lat == 0) begin
                lat = i;
                req[ch] = 1'b0;
                break;
            end
        end
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    function automatic int ch_of(input logic [3:0] onehot);
        for (int i = 0; i < 4; i++) if (onehot[i]) return i;
        return -1;
    endfunction

    initial begin
        int lat;
        int ack_ch[$];
        int ack_cyc[$];

        // Reset state and single request on channel 0.
        rst = 1'b1;
        repeat (2) tick();
        check("rst_led", 32'(led_pin), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        sw_pin = 8'b0000_0011;
        req = 4'b0001;
        wait_ack(0, 10, lat);
        check("single_latency", lat, 4);
        check("single_led", 32'(led_pin[1:0]), 32'b10);

        // Truth table on channel 2.
        for (int v = 0; v < 4; v++) begin
            sw_pin[5:4] = 2'(v);
            req = 4'b0100;
            wait_ack(2, 12, lat);
            check("tt_result", 32'(led_pin[4]), 32'(v != 3));
            check("tt_valid",  32'(led_pin[5]), 32'd1);
        end

        // Operand stability: switches change during EVAL.
        tick();
        sw_pin[3:2] = 2'b00;
        req = 4'b0010;
        tick();
        tick();
        sw_pin[3:2] = 2'b11;
        wait_ack(1, 10, lat);
        check("stable_result", 32'(led_pin[2]), 32'd1);

        // Early drop: one-cycle request pulse while idle.
        tick();
        req = 4'b1000;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) req = 4'b0000;
            if (ack[3] && lat == 0) lat = i;
        end
        check("drop_latency", lat, 4);
        check("drop_led", 32'(led_pin[7]), 32'd1);

        // Reset mid-EVAL, then contention from channel-0 priority.
        tick();
        req = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        check("midrst_led", 32'(led_pin), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 40 && ack_ch.size() < 5; i++) begin
            tick();
            if (ack != 4'd0) begin
                ack_ch.push_back(ch_of(ack));
                ack_cyc.push_back(cyc);
                check("cont_gnt", 32'(gnt_id), 32'(ack_ch.size() - 1) % 4);
            end
        end
        check("cont_count", ack_ch.size(), 5);
        for (int i = 0; i < ack_ch.size(); i++) begin
            check("cont_order", ack_ch[i], i % 4);
            if (i > 0) check("cont_gap", ack_cyc[i] - ack_cyc[i-1], H + 3);
        end
        req = 4'b0000;
        repeat (6) tick();

        // Random requesters, switches and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            sw_pin = 8'($urandom);
            for (int c = 0; c < 4; c++) begin
                if (req[c]) begin
                    if (m_ack[c] || $urandom_range(0, 15) == 0) req[c] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[c] = 1'b1;
                end
            end
        end
        rst = 1'b0;
        req = 4'b0000;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
